fir_accumulator: RTL
====================

Name: fir_accumulator

Overview:
- Downstream stage of the 32-bit ALU in the FIR datapath. Consumes one ALU result per accepted beat, typically a sample×coefficient product from ctrl=3.
- Sums TAPS consecutive results into one filter output word.
- Presents that word on a valid/ready output port to the write-back or output FIFO stage.
- Decouples the per-tap ALU issue rate from the per-sample consumer.

Parameters:
- WIDTH, 32, data width of the ALU result and of the accumulator.
- TAPS, 8, number of accepted beats summed per output word; legal range 1..255.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- clear  input  1  synchronous abort; discards any partial sum and any pending output.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  block can accept in_data this cycle.
- in_data  input  WIDTH  ALU result, two's complement.
- out_valid  output  1  out_data holds a completed sum.
- out_ready  input  1  consumer takes out_data this cycle.
- out_data  output  WIDTH  completed sum of TAPS beats.
- overflow  output  1  sticky signed-overflow flag for the current or pending sum.

Behaviour:
- Interface: one clock, clk. Reset is asynchronous and active-high, port reset.
- Reset: acc=0, tap_cnt=0, out_data=0, out_valid=0, overflow=0, state=ACCUM.
- Accept condition: in_valid && in_ready. in_ready = (state==ACCUM) && !clear, driven combinationally from registered state.
- States:
  - ACCUM: collecting beats.
  - FULL: holding a completed sum until the consumer takes it.
- ACCUM, on accept with tap_cnt < TAPS-1: acc <= acc + in_data (modulo 2^WIDTH); tap_cnt++.
- ACCUM, on accept with tap_cnt == TAPS-1:
  - out_data <= acc + in_data; out_valid <= 1.
  - acc <= 0; tap_cnt <= 0; state <= FULL.
  - Output latency: out_valid rises one cycle after the final accepted beat.
- FULL: in_ready=0. out_data and out_valid stay stable until out_valid && out_ready.
- FULL, on handshake: out_valid <= 0; overflow <= 0; state <= ACCUM. in_ready reasserts the next cycle, giving one bubble per output word.
- Arithmetic:
  - Two's-complement wrap; no saturation.
  - overflow sets when an addition's operands share a sign and the sum's sign differs.
  - overflow stays set until the output handshake, clear, or reset.
  - overflow is valid alongside out_valid.
- in_valid without in_ready: no state change; the producer must hold in_data.
- in_valid low mid-sum: acc and tap_cnt hold; no timeout.
- TAPS=1: every accepted beat goes straight to FULL with out_data=in_data.
- clear priority: above all except reset. It forces acc=0, tap_cnt=0, out_valid=0, overflow=0, state=ACCUM, and out_data holds its last value. A beat presented in the clear cycle is not accepted, because in_ready is low. clear and the out_ready handshake in the same cycle is treated as clear; the word counts as dropped.
- Reset mid-sum or while FULL: immediate return to reset values with no clock edge needed; the pending word is lost.
- tap_cnt width: clog2(TAPS+1) bits minimum.

Test Plan:
- Reset then TAPS=8, beats 1..8 back-to-back with out_ready=1: in_ready high for 8 cycles; out_valid pulses exactly 1 cycle after beat 8 with out_data=36, overflow=0; in_ready low 1 cycle, then high.
- Backpressure: complete a sum of 8×5=40 with out_ready=0 for 10 cycles: out_valid=1 and out_data=40 stable, in_ready=0 throughout, an extra in_valid beat is not consumed; raise out_ready, then the next 8 beats of 2 give 16.
- Overflow: beats 0x7FFFFFFF, 1, then six zeros: out_data=0x80000000, overflow=1 with out_valid; after the handshake, the next sum of eight zeros gives overflow=0. Also negative beats (-3 ×8): out_data=0xFFFFFFE8, overflow=0.
- clear after 5 beats of 10, then 8 beats of 1: the first partial sum is discarded; out_data=8. Also clear while FULL: out_valid drops the next cycle and no handshake occurs.
- Asynchronous reset asserted between clock edges at tap 3: out_valid, overflow and in-flight state zero without a clock edge; after release a fresh 8-beat sum of 3 gives out_data=24.
- TAPS=1 instance: beats 7, 9 with out_ready=1: out_data=7 then 9, each one cycle after acceptance, with in_ready alternating 1,0.

Source files
------------

// File: rtl/fir_accumulator.sv
// Sums TAPS consecutive ALU results into one filter output word and holds it
// on a valid/ready port until the downstream stage takes it.
module fir_accumulator #(
  parameter int WIDTH = 32,
  parameter int TAPS  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             overflow
);

  localparam int CNT_W = $clog2(TAPS + 1);
  localparam logic [CNT_W-1:0] LAST_TAP = CNT_W'(TAPS - 1);

  typedef enum logic {ACCUM, FULL} state_t;

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [CNT_W-1:0] tap_cnt;
  logic [WIDTH-1:0] sum;
  logic             add_ovf;
  logic             accept;

  assign in_ready = (state == ACCUM) && !clear;
  assign accept   = in_valid && in_ready;
  assign sum      = acc + in_data;

  // Signed overflow: operands agree in sign but the wrapped sum does not.
  assign add_ovf  = (acc[WIDTH-1] == in_data[WIDTH-1]) && (sum[WIDTH-1] != acc[WIDTH-1]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc       <= '0;
      tap_cnt   <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
      state     <= ACCUM;
    end else if (clear) begin
      acc       <= '0;
      tap_cnt   <= '0;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
      state     <= ACCUM;
    end else begin
      case (state)
        ACCUM: begin
          if (accept) begin
            if (add_ovf) overflow <= 1'b1;
            if (tap_cnt == LAST_TAP) begin
              out_data  <= sum;
              out_valid <= 1'b1;
              acc       <= '0;
              tap_cnt   <= '0;
              state     <= FULL;
            end else begin
              acc     <= sum;
              tap_cnt <= tap_cnt + 1'b1;
            end
          end
        end
        FULL: begin
          // The flag belongs to the word just delivered, so it retires with it.
          if (out_ready) begin
            out_valid <= 1'b0;
            overflow  <= 1'b0;
            state     <= ACCUM;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule
